// File: rtl/bsg_counter_pkg.sv
// Shared definitions for the set/down counter family.
//   bsg_counter_state_width_lp      : width of the state encoding
//   bsg_counter_set_down_state_e    : IDLE / RUN / EXPIRE
package bsg_counter_pkg;

  localparam int unsigned bsg_counter_state_width_lp = 2;

  typedef enum logic [bsg_counter_state_width_lp-1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EXPIRE = 2'd2
  } bsg_counter_set_down_state_e;

endpackage

// File: rtl/bsg_counter_set_down.sv
// Loadable down-counter / timer. A start value is loaded through a
// valid/ready handshake, down_i decrements it, and expired_o pulses for
// one cycle when the count reaches zero.
//
// Ports:
//   clk_i      : clock, rising edge
//   reset_i    : asynchronous active-high reset
//   set_v_i    : load request valid
//   val_i      : start value, taken when set_v_i & ready_o
//   ready_o    : load can be accepted this cycle (low while abort_i high)
//   abort_i    : synchronous cancel back to IDLE, no expiry pulse
//   down_i     : decrement request, effective only in RUN
//   count_o    : current count (registered)
//   busy_o     : high in RUN
//   expired_o  : one-cycle expiry pulse
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no count active, count_o = 0, down_i ignored
// RUN    | counting down on down_i
// EXPIRE | single cycle after the count hit zero, expired_o high
module bsg_counter_set_down
  import bsg_counter_pkg::*;
#(
  parameter int unsigned width_p       = 24,
  parameter bit          auto_reload_p = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               set_v_i,
  input  logic [width_p-1:0] val_i,
  output logic               ready_o,
  input  logic               abort_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o,
  output logic               busy_o,
  output logic               expired_o
);

  bsg_counter_set_down_state_e state_r, state_n;
  logic [width_p-1:0] count_r, count_n;
  logic [width_p-1:0] last_r, last_n;
  // Expiry pulse for the auto-reload case, where the FSM never leaves RUN.
  logic               reload_pulse_r, reload_pulse_n;
  logic               load;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r        <= IDLE;
      count_r        <= '0;
      last_r         <= '0;
      reload_pulse_r <= 1'b0;
    end else begin
      state_r        <= state_n;
      count_r        <= count_n;
      last_r         <= last_n;
      reload_pulse_r <= reload_pulse_n;
    end
  end

  // In auto-reload mode a new value may replace the running one.
  assign ready_o = !abort_i && ((state_r != RUN) || auto_reload_p);
  assign load    = set_v_i && ready_o;

  always_comb begin
    state_n        = state_r;
    count_n        = count_r;
    last_n         = last_r;
    reload_pulse_n = 1'b0;

    if (abort_i) begin
      state_n = IDLE;
      count_n = '0;
    end else if (load) begin
      count_n = val_i;
      last_n  = val_i;
      state_n = (val_i != '0) ? RUN : EXPIRE;
    end else begin
      unique case (state_r)
        RUN: begin
          if (down_i) begin
            if (count_r == width_p'(1)) begin
              if (auto_reload_p) begin
                count_n        = last_r;
                reload_pulse_n = 1'b1;
              end else begin
                count_n = '0;
                state_n = EXPIRE;
              end
            end else begin
              count_n = count_r - width_p'(1);
            end
          end
        end
        EXPIRE: begin
          state_n = IDLE;
          count_n = '0;
        end
        default: begin
          state_n = IDLE;
          count_n = '0;
        end
      endcase
    end
  end

  assign count_o   = count_r;
  assign busy_o    = (state_r == RUN);
  assign expired_o = (state_r == EXPIRE) || reload_pulse_r;

endmodule

// File: tb/tb_bsg_counter_set_down.sv
module tb_bsg_counter_set_down;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_v = 1'b0;
  logic [23:0] val = '0;
  logic        down = 1'b0;
  logic        abort = 1'b0;

  logic [23:0] cnt0;
  logic [3:0]  cnt1;
  logic [5:0]  cnt2;
  logic [2:0]  rdy, bsy, exp_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Three configurations driven in lockstep: default, narrow, auto-reload.
  bsg_counter_set_down u_main (
    .clk_i(clk), .reset_i(rst), .set_v_i(set_v), .val_i(val),
    .ready_o(rdy[0]), .abort_i(abort), .down_i(down), .count_o(cnt0),
    .busy_o(bsy[0]), .expired_o(exp_o[0])
  );

  bsg_counter_set_down #(.width_p(4)) u_w4 (
    .clk_i(clk), .reset_i(rst), .set_v_i(set_v), .val_i(val[3:0]),
    .ready_o(rdy[1]), .abort_i(abort), .down_i(down), .count_o(cnt1),
    .busy_o(bsy[1]), .expired_o(exp_o[1])
  );

  bsg_counter_set_down #(.width_p(6), .auto_reload_p(1'b1)) u_ar (
    .clk_i(clk), .reset_i(rst), .set_v_i(set_v), .val_i(val[5:0]),
    .ready_o(rdy[2]), .abort_i(abort), .down_i(down), .count_o(cnt2),
    .busy_o(bsy[2]), .expired_o(exp_o[2])
  );

  logic [63:0] obs_cnt [3];
  assign obs_cnt[0] = 64'(cnt0);
  assign obs_cnt[1] = 64'(cnt1);
  assign obs_cnt[2] = 64'(cnt2);

  // Reference model: phase 0 = idle, 1 = counting, 2 = just expired.
  int      cfg_w  [3] = '{24, 4, 6};
  bit      cfg_ar [3] = '{1'b0, 1'b0, 1'b1};
  int      m_phase [3];
  longint  m_cnt   [3];
  longint  m_last  [3];
  bit      m_pulse [3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_phase[i] = 0; m_cnt[i] = 0; m_last[i] = 0; m_pulse[i] = 1'b0;
    end
  endtask

  function automatic bit m_ready(int i);
    return !abort && (m_phase[i] != 1 || cfg_ar[i]);
  endfunction

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      longint mask = (longint'(1) << cfg_w[i]) - 1;
      longint v    = longint'(val) & mask;
      bit     rd   = m_ready(i);
      m_pulse[i] = 1'b0;
      if (abort) begin
        m_phase[i] = 0; m_cnt[i] = 0;
      end else if (set_v && rd) begin
        m_cnt[i] = v; m_last[i] = v;
        m_phase[i] = (v != 0) ? 1 : 2;
      end else if (m_phase[i] == 1 && down) begin
        if (m_cnt[i] > 1) m_cnt[i] = m_cnt[i] - 1;
        else if (cfg_ar[i]) begin
          m_cnt[i] = m_last[i]; m_pulse[i] = 1'b1;
        end else begin
          m_cnt[i] = 0; m_phase[i] = 2;
        end
      end else if (m_phase[i] == 2) begin
        m_phase[i] = 0; m_cnt[i] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string step);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s.count[%0d]", step, i), obs_cnt[i], 64'(m_cnt[i]));
      chk($sformatf("%s.ready[%0d]", step, i), 64'(rdy[i]), 64'(m_ready(i)));
      chk($sformatf("%s.busy[%0d]", step, i), 64'(bsy[i]), 64'(m_phase[i] == 1));
      chk($sformatf("%s.expired[%0d]", step, i), 64'(exp_o[i]),
          64'(m_phase[i] == 2 || m_pulse[i]));
    end
  endtask

  task automatic cyc(input string step, input bit s, input logic [23:0] v,
                     input bit d, input bit a);
    @(negedge clk);
    set_v = s; val = v; down = d; abort = a;
    #1;
    check_all(step);
    model_step();
    @(posedge clk);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Async reset in the middle of a count.
    cyc("rst_load", 1, 24'd5, 0, 0);
    cyc("rst_dn1", 0, 24'd0, 1, 0);
    cyc("rst_dn2", 0, 24'd0, 1, 0);
    @(negedge clk);
    set_v = 0; down = 0; abort = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    rst = 1'b0;

    // Basic countdown.
    cyc("cd_load", 1, 24'd3, 0, 0);
    for (int k = 0; k < 6; k++) cyc($sformatf("cd_dn%0d", k), 0, 24'd0, 1, 0);

    // Load zero, reload in the expire cycle, load attempt while running.
    cyc("z_load0", 1, 24'd0, 0, 0);
    cyc("z_load2", 1, 24'd2, 0, 0);
    cyc("z_busy_load", 1, 24'd7, 0, 0);
    cyc("z_hold", 0, 24'd0, 0, 0);
    for (int k = 0; k < 4; k++) cyc($sformatf("z_dn%0d", k), 0, 24'd0, 1, 0);

    // Abort beats decrement and load.
    cyc("ab_load1", 1, 24'd1, 0, 0);
    cyc("ab_abort", 1, 24'd4, 1, 1);
    cyc("ab_after", 0, 24'd0, 1, 0);
    cyc("ab_idle", 1, 24'd4, 0, 1);
    cyc("ab_idle2", 0, 24'd0, 0, 0);

    // All-ones in the narrow instance: 15 decrements to expiry, no wrap after.
    cyc("w_loadF", 1, 24'h00000F, 0, 0);
    for (int k = 0; k < 18; k++) cyc($sformatf("w_dn%0d", k), 0, 24'd0, 1, 0);

    // Auto-reload cadence, then abort.
    cyc("ar_load2", 1, 24'd2, 0, 0);
    for (int k = 0; k < 7; k++) cyc($sformatf("ar_dn%0d", k), 0, 24'd0, 1, 0);
    cyc("ar_abort", 0, 24'd0, 1, 1);
    cyc("ar_idle", 0, 24'd0, 1, 0);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      bit          s = ($urandom % 3) == 0;
      logic [23:0] v = (($urandom % 5) == 0) ? 24'($urandom) : 24'($urandom % 6);
      bit          d = ($urandom % 4) != 0;
      bit          a = ($urandom % 25) == 0;
      cyc("rnd", s, v, d, a);
    end

    @(negedge clk);
    set_v = 0; down = 0; abort = 0;
    #1;
    check_all("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
